// File: rtl/adpcm_encode_if.sv
// rtl/adpcm_encode_if.sv - block handshake and dual buffer-port bundle for adpcm_encode
// master = staging wrapper side, slave = encoder core side.
interface adpcm_encode_if #(
   parameter int ADDR_WID = 7,
   parameter int DATA_WID = 32
);
   logic                ap_start;
   logic                ap_done;
   logic                ap_idle;
   logic                ap_ready;
   logic [31:0]         ap_return;
   logic [ADDR_WID-1:0] buff_address0;
   logic                buff_ce0;
   logic                buff_we0;
   logic [DATA_WID-1:0] buff_d0;
   logic [DATA_WID-1:0] buff_q0;
   logic [ADDR_WID-1:0] buff_address1;
   logic                buff_ce1;
   logic                buff_we1;
   logic [DATA_WID-1:0] buff_d1;
   logic [DATA_WID-1:0] buff_q1;

   modport master (
      output ap_start, buff_q0, buff_q1,
      input  ap_done, ap_idle, ap_ready, ap_return,
      input  buff_address0, buff_ce0, buff_we0, buff_d0,
      input  buff_address1, buff_ce1, buff_we1, buff_d1
   );

   modport slave (
      input  ap_start, buff_q0, buff_q1,
      output ap_done, ap_idle, ap_ready, ap_return,
      output buff_address0, buff_ce0, buff_we0, buff_d0,
      output buff_address1, buff_ce1, buff_we1, buff_d1
   );
endinterface

// File: rtl/adpcm_encode.sv
// rtl/adpcm_encode.sv - in-place IMA ADPCM encoder core, 3 cycles per sample
// ADPCM_CHECKSUM_EN: ap_return carries the wrapping sum of emitted codes instead of {index, pred}.
module adpcm_encode #(
   parameter int ADDR_WID  = 7,
   parameter int DATA_WID  = 32,
   parameter int N_SAMPLES = 128
) (
   input  logic          ap_clk,
   input  logic          ap_rst_n,
   adpcm_encode_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_DONE} state_t;

   localparam logic [ADDR_WID-1:0] LAST_IDX = ADDR_WID'(N_SAMPLES - 1);

   localparam logic [14:0] STEP_TBL [89] = '{
      15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
      15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
      15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
      15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
      15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
      15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
      15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
      15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
      15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
      15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
      15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
      15'd32767
   };

   localparam logic signed [7:0] IDX_TBL [8] = '{
      -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
   };

   state_t              state_q;
   logic [ADDR_WID-1:0] i_q;
   logic signed [15:0]  pred_q;
   logic [6:0]          index_q;
   logic                idle_q;
   logic                done_q;
   logic                ce0_q;
   logic                ce1_q;
   logic [ADDR_WID-1:0] addr0_q;
   logic [ADDR_WID-1:0] addr1_q;
   logic [DATA_WID-1:0] d1_q;
   logic [31:0]         ret_q;
`ifdef ADPCM_CHECKSUM_EN
   logic [31:0]         sum_q;
`endif

   logic signed [15:0]  sample;
   logic signed [17:0]  diff;
   logic                sign;
   logic [17:0]         mag;
   logic [17:0]         step18;
   logic [17:0]         vp;
   logic [3:0]          code_d;
   logic signed [17:0]  pred_sum;
   logic signed [15:0]  pred_d;
   logic signed [7:0]   idx_sum;
   logic [6:0]          index_d;

   // Only the low half of each buffer word carries PCM; port 1 is write-only.
   logic unused_bits;
   assign unused_bits = ^{bus.buff_q1, bus.buff_q0[DATA_WID-1:16]};

   always_comb begin
      sample   = $signed(bus.buff_q0[15:0]);
      diff     = {{2{sample[15]}}, sample} - {{2{pred_q[15]}}, pred_q};
      sign     = diff[17];
      mag      = sign ? 18'(-diff) : 18'(diff);
      step18   = {3'b000, STEP_TBL[index_q]};
      vp       = step18 >> 3;
      code_d   = 4'd0;
      if (mag >= step18) begin
         code_d[2] = 1'b1;
         mag       = mag - step18;
         vp        = vp + step18;
      end
      if (mag >= (step18 >> 1)) begin
         code_d[1] = 1'b1;
         mag       = mag - (step18 >> 1);
         vp        = vp + (step18 >> 1);
      end
      if (mag >= (step18 >> 2)) begin
         code_d[0] = 1'b1;
         vp        = vp + (step18 >> 2);
      end
      code_d[3] = sign;

      // 18 bits hold |pred| + vp without wrap, so saturation sees the true value.
      pred_sum = sign ? ({{2{pred_q[15]}}, pred_q} - vp) : ({{2{pred_q[15]}}, pred_q} + vp);
      if (pred_sum > 18'sd32767)
         pred_d = 16'sd32767;
      else if (pred_sum < -18'sd32768)
         pred_d = -16'sd32768;
      else
         pred_d = pred_sum[15:0];

      idx_sum = $signed({1'b0, index_q}) + IDX_TBL[code_d[2:0]];
      if (idx_sum < 8'sd0)
         index_d = 7'd0;
      else if (idx_sum > 8'sd88)
         index_d = 7'd88;
      else
         index_d = idx_sum[6:0];
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         pred_q  <= '0;
         index_q <= '0;
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
         ce0_q   <= 1'b0;
         ce1_q   <= 1'b0;
         addr0_q <= '0;
         addr1_q <= '0;
         d1_q    <= '0;
         ret_q   <= '0;
`ifdef ADPCM_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         ce0_q  <= 1'b0;
         ce1_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.ap_start) begin
                  pred_q  <= '0;
                  index_q <= '0;
                  i_q     <= '0;
                  addr0_q <= '0;
                  ce0_q   <= 1'b1;
                  idle_q  <= 1'b0;
`ifdef ADPCM_CHECKSUM_EN
                  sum_q   <= '0;
`endif
                  state_q <= S_RD;
               end
            end
            S_RD: begin
               state_q <= S_CALC;
            end
            S_CALC: begin
               pred_q  <= pred_d;
               index_q <= index_d;
               ce1_q   <= 1'b1;
               addr1_q <= i_q;
               d1_q    <= {{(DATA_WID-4){1'b0}}, code_d};
`ifdef ADPCM_CHECKSUM_EN
               sum_q   <= sum_q + {28'd0, code_d};
`endif
               state_q <= S_WR;
            end
            S_WR: begin
               if (i_q == LAST_IDX) begin
                  done_q  <= 1'b1;
`ifdef ADPCM_CHECKSUM_EN
                  ret_q   <= sum_q;
`else
                  ret_q   <= {8'd0, 1'b0, index_q, pred_q};
`endif
                  state_q <= S_DONE;
               end else begin
                  i_q     <= i_q + 1'b1;
                  addr0_q <= i_q + 1'b1;
                  ce0_q   <= 1'b1;
                  state_q <= S_RD;
               end
            end
            S_DONE: begin
               idle_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               idle_q  <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ap_idle       = idle_q;
   assign bus.ap_done       = done_q;
   assign bus.ap_ready      = done_q;
   assign bus.ap_return     = ret_q;
   assign bus.buff_address0 = addr0_q;
   assign bus.buff_ce0      = ce0_q;
   assign bus.buff_we0      = 1'b0;
   assign bus.buff_d0       = '0;
   assign bus.buff_address1 = addr1_q;
   assign bus.buff_ce1      = ce1_q;
   assign bus.buff_we1      = ce1_q;
   assign bus.buff_d1       = d1_q;
endmodule

// File: tb/tb_adpcm_encode.sv
// tb/tb_adpcm_encode.sv - self-checking bench for adpcm_encode against an integer IMA model
module tb_adpcm_encode;
   localparam int N = 128;

   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b0;
   logic load_req = 1'b0;

   adpcm_encode_if #(.ADDR_WID(7), .DATA_WID(32)) bus ();

   adpcm_encode #(.ADDR_WID(7), .DATA_WID(32), .N_SAMPLES(N)) dut (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .bus     (bus)
   );

   always #5 ap_clk = ~ap_clk;

   int STEP_T [89] = '{
      7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
      50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253,
      279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166,
      1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428,
      4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289,
      16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
   };
   int IDX_T [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

   logic [31:0] mem  [N];
   logic [31:0] samp [N];
   int          ref_codes [N];
   logic [31:0] ref_ret;
   int          wr_count = 0;
   int          checks   = 0;
   int          failures = 0;

   // Buffer RAM: one-cycle read latency on port 0, write on port 1.
   always @(posedge ap_clk) begin
      if (load_req) begin
         for (int k = 0; k < N; k++) mem[k] = samp[k];
      end
      if (bus.buff_ce0) bus.buff_q0 <= mem[bus.buff_address0];
      if (bus.buff_ce1) begin
         wr_count = wr_count + 1;
         if (bus.buff_we1) mem[bus.buff_address1] = bus.buff_d1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model();
      int pred, idx, s, diff, step, vp, code, sum;
      bit sign;
      pred = 0; idx = 0; sum = 0;
      for (int k = 0; k < N; k++) begin
         s    = int'($signed(samp[k][15:0]));
         step = STEP_T[idx];
         diff = s - pred;
         sign = diff < 0;
         if (sign) diff = -diff;
         code = 0;
         vp   = step / 8;
         if (diff >= step)     begin code += 4; diff -= step;     vp += step;     end
         if (diff >= step / 2) begin code += 2; diff -= step / 2; vp += step / 2; end
         if (diff >= step / 4) begin code += 1;                   vp += step / 4; end
         pred = sign ? pred - vp : pred + vp;
         if (pred > 32767)  pred = 32767;
         if (pred < -32768) pred = -32768;
         idx = idx + IDX_T[code];
         if (idx < 0)  idx = 0;
         if (idx > 88) idx = 88;
         if (sign) code += 8;
         ref_codes[k] = code;
         sum += code;
      end
`ifdef ADPCM_CHECKSUM_EN
      ref_ret = 32'(sum);
`else
      ref_ret = {8'h00, idx[7:0], pred[15:0]};
`endif
   endtask

   task automatic load();
      load_req = 1'b1;
      @(posedge ap_clk);
      #1 load_req = 1'b0;
   endtask

   task automatic run_check(input string tag, input bit glitch);
      int n, w0;
      load();
      model();
      w0 = wr_count;
      bus.ap_start = 1'b1;
      @(posedge ap_clk);
      #1 bus.ap_start = 1'b0;
      n = 0;
      while (n < 1000) begin
         @(posedge ap_clk);
         #1 n++;
         if (n == 1) check({tag, "_idle_busy"}, 32'(bus.ap_idle), 32'd0);
         if (glitch && n == 40) bus.ap_start = 1'b1;
         if (glitch && n == 41) bus.ap_start = 1'b0;
         if (bus.ap_done) break;
      end
      check({tag, "_latency"}, 32'(n), 32'd384);
      check({tag, "_ready"}, 32'(bus.ap_ready), 32'd1);
      check({tag, "_writes"}, 32'(wr_count - w0), 32'd128);
      check({tag, "_return"}, bus.ap_return, ref_ret);
      for (int k = 0; k < N; k++)
         check($sformatf("%s_code%0d", tag, k), mem[k], 32'(ref_codes[k]));
      @(posedge ap_clk);
      #1;
      check({tag, "_idle_after"}, 32'(bus.ap_idle), 32'd1);
      check({tag, "_done_after"}, 32'(bus.ap_done), 32'd0);
   endtask

   initial begin
      logic [31:0] ret_a;
      int n, m, w0;
      bus.ap_start = 1'b0;
      bus.buff_q1  = '0;
      ap_rst_n     = 1'b0;
      repeat (3) @(posedge ap_clk);
      #1;
      check("rst_idle", 32'(bus.ap_idle), 32'd1);
      check("rst_done", 32'(bus.ap_done), 32'd0);
      check("rst_ce0", 32'(bus.buff_ce0), 32'd0);
      check("rst_ce1", 32'(bus.buff_ce1), 32'd0);
      check("rst_return", bus.ap_return, 32'd0);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;

      for (int k = 0; k < N; k++) samp[k] = 32'd0;
      run_check("zero", 1'b0);

      for (int k = 0; k < N; k++) samp[k] = 32'd1000;
      run_check("c1000", 1'b0);
      check("c1000_s0", mem[0], 32'd7);
      check("c1000_s1", mem[1], 32'd7);

      for (int k = 0; k < N; k++) samp[k] = $urandom;
      samp[0] = 32'h0000FC18;
      run_check("neg", 1'b0);
      check("neg_s0", mem[0], 32'hF);
      ret_a = bus.ap_return;
      samp[0] = 32'hABCDFC18;
      run_check("neg_hi", 1'b0);
      check("neg_hi_same", bus.ap_return, ret_a);

      for (int k = 0; k < N; k++) samp[k] = k[0] ? 32'hFFFF8001 : 32'h00007FFF;
      run_check("alt", 1'b0);
`ifndef ADPCM_CHECKSUM_EN
      check("alt_idx_range", 32'(bus.ap_return[23:16] <= 8'd88), 32'd1);
`endif

      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < N; k++) samp[k] = $urandom;
         run_check($sformatf("rand%0d", r), 1'b1);
      end

      // start held high: back-to-back runs, second one re-encodes the codes in place
      for (int k = 0; k < N; k++) samp[k] = $urandom;
      load();
      model();
      bus.ap_start = 1'b1;
      @(posedge ap_clk);
      #1 n = 0;
      while (n < 1000) begin
         @(posedge ap_clk);
         #1 n++;
         if (bus.ap_done) break;
      end
      check("held_latency1", 32'(n), 32'd384);
      check("held_return1", bus.ap_return, ref_ret);
      for (int k = 0; k < N; k++) samp[k] = 32'(ref_codes[k]);
      model();
      m = 0;
      while (m < 1000) begin
         @(posedge ap_clk);
         #1 m++;
         if (m == 2) bus.ap_start = 1'b0;
         if (bus.ap_done) break;
      end
      check("held_gap", 32'(m), 32'd386);
      check("held_return2", bus.ap_return, ref_ret);
      @(posedge ap_clk);
      #1;

      // reset in the middle of a run, with an ignored start pulse first
      for (int k = 0; k < N; k++) samp[k] = $urandom;
      load();
      bus.ap_start = 1'b1;
      @(posedge ap_clk);
      #1 bus.ap_start = 1'b0;
      repeat (49) @(posedge ap_clk);
      #1 bus.ap_start = 1'b1;
      @(posedge ap_clk);
      #1 bus.ap_start = 1'b0;
      repeat (49) @(posedge ap_clk);
      #1 ap_rst_n = 1'b0;
      @(posedge ap_clk);
      #1;
      check("mid_rst_idle", 32'(bus.ap_idle), 32'd1);
      check("mid_rst_ce0", 32'(bus.buff_ce0), 32'd0);
      check("mid_rst_ce1", 32'(bus.buff_ce1), 32'd0);
      check("mid_rst_done", 32'(bus.ap_done), 32'd0);
      check("mid_rst_return", bus.ap_return, 32'd0);
      w0 = wr_count;
      ap_rst_n = 1'b1;
      repeat (30) @(posedge ap_clk);
      #1;
      check("mid_rst_nowrites", 32'(wr_count - w0), 32'd0);
      check("mid_rst_still_idle", 32'(bus.ap_idle), 32'd1);

      for (int k = 0; k < N; k++) samp[k] = $urandom;
      run_check("fresh", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adpcm_encode.md
# adpcm_encode

In-place IMA ADPCM encoder core with an HLS-style block-level handshake. It sits behind the memory-staging wrapper that loads a 128-word buffer, pulses start, services the two buffer RAM ports, and then drains the buffer. The core reads each 16-bit PCM sample from the buffer and overwrites it with its 4-bit ADPCM code. It returns the final encoder state on `ap_return`.

## Interface
- `ADDR_WID`, 7, buffer address width.
- `DATA_WID`, 32, buffer word width.
- `N_SAMPLES`, 128, samples encoded per invocation (≤ 2^ADDR_WID).

Ports:
- `ap_clk` in 1: the single clock; all logic on the rising edge.
- `ap_rst_n` in 1: reset, synchronous, active-low.
- `ap_start` in 1: start request, sampled only in IDLE.
- `ap_done` out 1: one-cycle pulse at completion.
- `ap_idle` out 1: high while in IDLE.
- `ap_ready` out 1: pulses together with `ap_done`.
- `buff_address0` out ADDR_WID: read address.
- `buff_ce0` out 1: read enable.
- `buff_we0` out 1: tied 0.
- `buff_d0` out DATA_WID: tied 0.
- `buff_q0` in DATA_WID: read data, valid the cycle after the `ce0` cycle.
- `buff_address1` out ADDR_WID: write address.
- `buff_ce1` out 1: write enable.
- `buff_we1` out 1: write strobe, equal to `ce1`.
- `buff_d1` out DATA_WID: write data.
- `buff_q1` in DATA_WID: unused.
- `ap_return` out 32: final encoder state.

## Operation
- FSM states: IDLE, RD, CALC, WR, DONE.
- IDLE:
  - `ap_idle`=1.
  - On `ap_start`=1: predictor←0, index←0, i←0, go to RD.
- RD: `ce0`=1, `address0`=i. Go to CALC.
- CALC:
  - sample = signed `buff_q0[15:0]`; bits 31:16 are ignored.
  - step = STEP[index], using the standard 89-entry IMA step table (7, 8, 9, 10, 11, 12, 13, 14, 16, … 32767).
  - diff = sample − pred in 18-bit signed. sign = diff<0. If sign, diff = −diff.
  - vp = step>>3.
  - If diff≥step: code|=4, diff−=step, vp+=step.
  - If diff≥step>>1: code|=2, diff−=step>>1, vp+=step>>1.
  - If diff≥step>>2: code|=1, vp+=step>>2.
  - If sign: code|=8.
  - pred = sign ? pred−vp : pred+vp, saturated to [−32768, 32767].
  - index += IDX[code[2:0]], where IDX = {−1,−1,−1,−1,2,4,6,8}; clamp index to [0, 88].
  - Register code, pred and index. Go to WR.
- WR:
  - `ce1`=`we1`=1, `address1`=i, `d1`={28'b0, code}.
  - If i==N_SAMPLES−1 go to DONE, else i←i+1 and go to RD.
- DONE:
  - `ap_done`=`ap_ready`=1.
  - `ap_return`←{8'b0, index[7:0], pred[15:0]}, held until the next start.
  - Go to IDLE.
- `ap_start` outside IDLE is ignored.
- If `ap_start` is held high, the next run begins at the edge after the IDLE cycle that follows DONE.
- Port 0 only reads and port 1 only writes, so the two ports never access the same address in the same cycle.

## Timing
- Reset values: state IDLE, `ap_idle`=1, `ap_done`=`ap_ready`=0, all `ce`/`we`=0, addresses=0, `d1`=0, `ap_return`=0, pred=0, index=0.
- Reset asserted mid-run: next cycle is IDLE with all outputs at reset values. No further buffer writes occur.
- 3 cycles per sample.
- With `ap_start` sampled at edge 0, `ap_done` is high in the cycle after edge 3·N_SAMPLES (for N_SAMPLES=128: after edge 384).
- `ap_idle` is 0 from edge 0 until the edge that ends DONE.

## Configuration
- `ADPCM_CHECKSUM_EN`:
  - When defined, `ap_return` = 32-bit wrapping sum of all emitted 4-bit codes.
  - When undefined, `ap_return` = {8'b0, index, pred}.
  - Encoding and buffer writes are identical in both builds.

## Test plan
- Reset: hold `ap_rst_n`=0 for 3 cycles → `ap_idle`=1, `ap_done`=0, `ce0`=`ce1`=0, `ap_return`=0.
- All-zero buffer, start → 128 writes of 0, `ap_done` after 384 edges, `ap_return`=0x00000000 (0 with checksum).
- Constant 1000:
  - sample 0 → code 7 (pred 11, index 8).
  - sample 1 → code 7 (pred 41, index 16).
- Sample 0 = 0x0000FC18 (−1000) → code 0xF, pred −11, index 8; bits 31:16 set to 0xABCD give identical results.
- Start pulse during a run and reset asserted at edge 100 → start ignored. After reset, state is IDLE with no further `ce1` writes, and the next start runs a fresh encode from pred=0, index=0.
- Full-scale alternating ±32767 → pred never leaves [−32768, 32767], index stays ≤88, `ap_return` matches a golden software IMA model.
